debug_unit_dumper: RTL and testbench

//  UART-driven debug controller for the pipelined MIPS. Decodes single-byte commands
//  (step, run, halt, dump), gates the pipeline via o_step, then serialises a full state

---
 rtl/debug_unit_dumper.sv | 142 ++++++++++++++
 tb/tb_debug_unit_dumper.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit_dumper.sv
// UART debug controller for the pipelined MIPS: runs step/run/halt/dump commands
// and sends a PC/regfile/ALU/memory snapshot to the UART TX, MSB byte first.
module debug_unit_dumper #(
  parameter int          NB               = 32,
  parameter int          DATA_BITS        = 8,
  parameter int          NUMBER_REGISTERS = 32,
  parameter int          NUMBER_MEM_WORDS = 16,
  parameter logic [7:0]  CMD_STEP         = 8'h73,
  parameter logic [7:0]  CMD_RUN          = 8'h63,
  parameter logic [7:0]  CMD_HALT         = 8'h68,
  parameter logic [7:0]  CMD_DUMP         = 8'h64
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_uart_rx_ready,
  input  logic [DATA_BITS-1:0]                  i_uart_rx_data,
  input  logic                                  i_uart_tx_done,
  input  logic [NB-1:0]                         i_mips_pc,
  input  logic [NB-1:0]                         i_mips_register,
  input  logic [NB-1:0]                         i_mips_alu_result,
  input  logic [NB-1:0]                         i_mips_mem_data,
  input  logic                                  i_mips_halted,
  output logic [$clog2(NUMBER_REGISTERS+1)-1:0] o_mips_register_number,
  output logic [$clog2(NUMBER_MEM_WORDS+1)-1:0] o_mips_mem_addr,
  output logic [DATA_BITS-1:0]                  o_uart_tx_data,
  output logic                                  o_uart_tx_ready,
  output logic                                  o_step,
  output logic                                  o_busy
);
  localparam int BYTES = NB / DATA_BITS;
  localparam int WORDS = 2 + NUMBER_REGISTERS + NUMBER_MEM_WORDS;
  localparam int IW    = $clog2(WORDS);
  localparam int RW    = $clog2(NUMBER_REGISTERS + 1);
  localparam int MW    = $clog2(NUMBER_MEM_WORDS + 1);
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [IW-1:0] IDX_ALU  = IW'(NUMBER_REGISTERS + 1);
  localparam logic [IW-1:0] IDX_MEM0 = IW'(NUMBER_REGISTERS + 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_RUN, S_FETCH, S_LATCH, S_SEND, S_WAIT_DONE
  } state_t;

  state_t          r_state, w_next;
  logic [NB-1:0]   r_shift;
  logic [IW-1:0]   r_word_idx;
  logic [BW-1:0]   r_byte_cnt;
  logic [RW-1:0]   r_reg_num;
  logic [MW-1:0]   r_mem_addr;
  logic [NB-1:0]   w_word;
  logic [IW-1:0]   w_reg_off, w_mem_off;
  logic            w_is_reg, w_is_mem, w_last_byte, w_cmd_halt;

  assign w_is_reg    = (r_word_idx != '0) && (r_word_idx < IDX_ALU);
  assign w_is_mem    = (r_word_idx >= IDX_MEM0);
  assign w_reg_off   = r_word_idx - IW'(1);
  assign w_mem_off   = r_word_idx - IDX_MEM0;
  assign w_last_byte = (r_byte_cnt == BW'(BYTES - 1));
  assign w_cmd_halt  = i_uart_rx_ready && (i_uart_rx_data == DATA_BITS'(CMD_HALT));

  // Addresses are presented combinationally in FETCH so the 1-cycle read lands in LATCH
  assign o_mips_register_number = (r_state == S_FETCH && w_is_reg) ? RW'(w_reg_off) : r_reg_num;
  assign o_mips_mem_addr        = (r_state == S_FETCH && w_is_mem) ? MW'(w_mem_off) : r_mem_addr;
  assign o_uart_tx_data         = r_shift[NB-1 -: DATA_BITS];
  assign o_busy                 = (r_state != S_IDLE);

  always_comb begin
    w_word = i_mips_mem_data;
    if (r_word_idx == '0)          w_word = i_mips_pc;
    else if (w_is_reg)             w_word = i_mips_register;
    else if (r_word_idx == IDX_ALU) w_word = i_mips_alu_result;
  end

  always_comb begin
    w_next          = r_state;
    o_step          = 1'b0;
    o_uart_tx_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_uart_rx_ready) begin
          if (i_uart_rx_data == DATA_BITS'(CMD_STEP))      w_next = S_STEP;
          else if (i_uart_rx_data == DATA_BITS'(CMD_RUN))  w_next = S_RUN;
          else if (i_uart_rx_data == DATA_BITS'(CMD_DUMP)) w_next = S_FETCH;
        end
      end
      S_STEP: begin
        o_step = 1'b1;
        w_next = S_FETCH;
      end
      S_RUN: begin
        if (i_mips_halted || w_cmd_halt) w_next = S_FETCH;
        else                             o_step = 1'b1;
      end
      S_FETCH: w_next = S_LATCH;
      S_LATCH: w_next = S_SEND;
      S_SEND: begin
        o_uart_tx_ready = 1'b1;
        if (i_uart_tx_done) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!w_last_byte)                w_next = S_SEND;
        else if (r_word_idx == IDX_LAST) w_next = S_IDLE;
        else                             w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_reg_num  <= '0;
      r_mem_addr <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_FETCH: begin
          r_reg_num  <= o_mips_register_number;
          r_mem_addr <= o_mips_mem_addr;
        end
        S_LATCH: begin
          r_shift    <= w_word;
          r_byte_cnt <= '0;
        end
        S_WAIT_DONE: begin
          r_shift <= r_shift << DATA_BITS;
          if (w_last_byte) begin
            r_byte_cnt <= '0;
            r_word_idx <= (r_word_idx == IDX_LAST) ? '0 : r_word_idx + IW'(1);
          end else begin
            r_byte_cnt <= r_byte_cnt + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_unit_dumper.sv
// Directed/random bench for debug_unit_dumper with a word-list reference model
// and 1-cycle registered regfile/memory models.
module tb_debug_unit_dumper;
  localparam int NB = 32, DB = 8, NR = 5, NM = 3;

  logic          clk = 1'b0, rst = 1'b1;
  logic          rx_ready = 1'b0, tx_done = 1'b1, halted = 1'b0;
  logic [DB-1:0] rx_data = '0;
  logic [NB-1:0] pc = '0, alu = '0, reg_rd = '0, mem_rd = '0;
  logic [2:0]    reg_num;
  logic [1:0]    mem_addr;
  logic [DB-1:0] tx_data;
  logic          tx_ready, step, busy;

  logic [NB-1:0] regs_m [0:7];
  logic [NB-1:0] mem_m  [0:3];
  logic [DB-1:0] got [$];
  logic [NB-1:0] exp_w [$];
  int n_checks = 0, n_err = 0;
  int nsteps, nready;

  debug_unit_dumper #(.NB(NB), .DATA_BITS(DB), .NUMBER_REGISTERS(NR), .NUMBER_MEM_WORDS(NM)) dut (
    .i_clk(clk), .i_reset(rst), .i_uart_rx_ready(rx_ready), .i_uart_rx_data(rx_data),
    .i_uart_tx_done(tx_done), .i_mips_pc(pc), .i_mips_register(reg_rd),
    .i_mips_alu_result(alu), .i_mips_mem_data(mem_rd), .i_mips_halted(halted),
    .o_mips_register_number(reg_num), .o_mips_mem_addr(mem_addr),
    .o_uart_tx_data(tx_data), .o_uart_tx_ready(tx_ready), .o_step(step), .o_busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    reg_rd <= regs_m[reg_num];
    mem_rd <= mem_m[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_state();
    pc  = $urandom;
    alu = $urandom;
    for (int i = 0; i < 8; i++) regs_m[i] = $urandom;
    for (int i = 0; i < 4; i++) mem_m[i] = $urandom;
  endtask

  // Snapshot order: PC, R0..R(NR-1), ALU, M0..M(NM-1)
  task automatic build_exp();
    exp_w.delete();
    exp_w.push_back(pc);
    for (int i = 0; i < NR; i++) exp_w.push_back(regs_m[i]);
    exp_w.push_back(alu);
    for (int i = 0; i < NM; i++) exp_w.push_back(mem_m[i]);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk);
    rx_data  = c;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Gathers one byte per tx_ready rising edge until busy drops or max_bytes seen
  task automatic collect(input int max_bytes, input bit rand_done, input bit bump_pc,
                         output int steps, output int readies);
    bit prev = 1'b0;
    int cyc = 0;
    got.delete();
    steps = 0;
    readies = 0;
    while (1) begin
      if (step) steps++;
      if (tx_ready) readies++;
      if (tx_ready && !prev) begin
        got.push_back(tx_data);
        if (bump_pc && got.size() == 1) pc = ~pc;
      end
      prev = tx_ready;
      if (got.size() == max_bytes) break;
      if (!busy) break;
      cyc++;
      if (cyc > 3000) begin
        check("collect_timeout", 64'd1, 64'd0);
        break;
      end
      if (rand_done) tx_done = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    tx_done = 1'b1;
  endtask

  task automatic check_dump(input string tag);
    logic [NB-1:0] word;
    check({tag, "_nbytes"}, 64'(got.size()), 64'(exp_w.size() * 4));
    for (int w = 0; w < exp_w.size(); w++) begin
      word = '0;
      for (int b = 0; b < 4; b++)
        word = (word << 8) | ((4 * w + b < got.size()) ? NB'(got[4 * w + b]) : '0);
      check($sformatf("%s_w%0d", tag, w), 64'(word), 64'(exp_w[w]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, 64'(tx_data), 64'd0);
    check({tag, "_tx_ready"}, 64'(tx_ready), 64'd0);
    check({tag, "_step"}, 64'(step), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_reg_num"}, 64'(reg_num), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
  endtask

  initial begin
    int cnt;
    logic [NB-1:0] pc_saved;
    randomize_state();

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // rx_data without rx_ready, then unknown byte with rx_ready, then idle halt
    rx_data = 8'h44;
    repeat (3) @(negedge clk);
    send_cmd(8'h44);
    send_cmd(8'h68);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cnt += int'(busy) + int'(step) + int'(tx_ready);
      @(negedge clk);
    end
    check("ignored_cmds_activity", 64'(cnt), 64'd0);

    // Single step with PC changing after it is latched
    randomize_state();
    pc = 32'h1ba5e93f;
    tx_done = 1'b1;
    send_cmd(8'h73);
    check("step_high", 64'(step), 64'd1);
    build_exp();
    @(negedge clk);
    check("step_one_cycle", 64'(step), 64'd0);
    collect(1000, 1'b0, 1'b1, nsteps, nready);
    check("step_b0", 64'(got.size() > 0 ? got[0] : 8'h00), 64'h1b);
    check("step_b1", 64'(got.size() > 1 ? got[1] : 8'h00), 64'ha5);
    check("step_b2", 64'(got.size() > 2 ? got[2] : 8'h00), 64'he9);
    check("step_b3", 64'(got.size() > 3 ? got[3] : 8'h00), 64'h3f);
    check("step_extra_steps", 64'(nsteps), 64'd0);
    check_dump("step_dump");

    // Plain dump with done held high: one ready cycle per byte
    randomize_state();
    build_exp();
    send_cmd(8'h64);
    collect(1000, 1'b0, 1'b0, nsteps, nready);
    check_dump("dump");
    check("dump_ready_cycles", 64'(nready), 64'd40);
    check("dump_busy_end", 64'(busy), 64'd0);

    // Dump with random tx_done handshake
    randomize_state();
    build_exp();
    send_cmd(8'h64);
    collect(1000, 1'b1, 1'b0, nsteps, nready);
    check_dump("dump_rand");
    check("dump_rand_busy_end", 64'(busy), 64'd0);

    // Run until halted
    randomize_state();
    build_exp();
    send_cmd(8'h63);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (step) cnt++;
      @(negedge clk);
    end
    halted = 1'b1;
    #1;
    check("run_halted_step_drop", 64'(step), 64'd0);
    check("run_halted_step_cnt", 64'(cnt), 64'd20);
    collect(1000, 1'b0, 1'b0, nsteps, nready);
    halted = 1'b0;
    check("run_halted_dump_steps", 64'(nsteps), 64'd0);
    check_dump("run_halted_dump");

    // Run until 'h' command
    randomize_state();
    build_exp();
    send_cmd(8'h63);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (step) cnt++;
      @(negedge clk);
    end
    rx_data  = 8'h68;
    rx_ready = 1'b1;
    #1;
    check("run_cmd_step_drop", 64'(step), 64'd0);
    check("run_cmd_step_cnt", 64'(cnt), 64'd20);
    @(negedge clk);
    rx_ready = 1'b0;
    collect(1000, 1'b0, 1'b0, nsteps, nready);
    check("run_cmd_dump_steps", 64'(nsteps), 64'd0);
    check_dump("run_cmd_dump");

    // 's' mid-dump ignored, then reset during byte 2, then fresh dump
    randomize_state();
    pc_saved = pc;
    send_cmd(8'h64);
    send_cmd(8'h73);
    collect(2, 1'b0, 1'b0, nsteps, nready);
    check("middump_steps", 64'(nsteps), 64'd0);
    check("middump_b0", 64'(got.size() > 0 ? got[0] : 8'h00), 64'(pc_saved[31:24]));
    check("middump_b1", 64'(got.size() > 1 ? got[1] : 8'h00), 64'(pc_saved[23:16]));
    check("middump_ready_before_reset", 64'(tx_ready), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    build_exp();
    send_cmd(8'h64);
    collect(1000, 1'b0, 1'b0, nsteps, nready);
    check_dump("after_reset_dump");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
